// File: rtl/dma_mem_responder_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces for dma_mem_responder.
//
// axis_mem_cmd_if : DMA command channel (byte address + byte length).
//   address[63:0], length[31:0], valid  : master -> slave
//   ready                               : slave  -> master
//
// axi_stream_if   : 512-bit data stream with per-byte keep.
//   data[511:0], keep[63:0], last, valid : master -> slave
//   ready                                : slave  -> master
// -----------------------------------------------------------------------------
interface axis_mem_cmd_if;
  logic [63:0] address;
  logic [31:0] length;
  logic        valid;
  logic        ready;

  modport master (output address, output length, output valid, input ready);
  modport slave  (input address, input length, input valid, output ready);
endinterface

interface axi_stream_if;
  logic [511:0] data;
  logic [63:0]  keep;
  logic         last;
  logic         valid;
  logic         ready;

  modport master (output data, output keep, output last, output valid, input ready);
  modport slave  (input data, input keep, input last, input valid, output ready);
endinterface

// File: rtl/dma_mem_responder.sv
// -----------------------------------------------------------------------------
// dma_mem_responder
//
// Stands in for the DMA engine plus host memory. Read commands are served as
// 512-bit bursts out of an internal memory; write commands absorb 512-bit
// bursts into it with per-byte enables. Read and write paths are independent.
//
// Ports:
//   user_clk              sole clock
//   user_rst              synchronous active-high reset
//   s_axis_dma_read_cmd   read commands  (slave)
//   s_axis_dma_write_cmd  write commands (slave)
//   m_axis_dma_read_data  read data burst out (master)
//   s_axis_dma_write_data write data burst in (slave)
//   o_rd_cmd_cnt          accepted read commands (wraps)
//   o_wr_cmd_cnt          accepted write commands (wraps)
//   o_wr_err_cnt          write bursts whose last position disagreed with length
// -----------------------------------------------------------------------------
module dma_mem_responder #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic                 user_clk,
  input  logic                 user_rst,
  axis_mem_cmd_if.slave        s_axis_dma_read_cmd,
  axis_mem_cmd_if.slave        s_axis_dma_write_cmd,
  axi_stream_if.master         m_axis_dma_read_data,
  axi_stream_if.slave          s_axis_dma_write_data,
  output logic [31:0]          o_rd_cmd_cnt,
  output logic [31:0]          o_wr_cmd_cnt,
  output logic [31:0]          o_wr_err_cnt
);
  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [0:0] RD_IDLE  = 1'b0;
  localparam logic [0:0] RD_BURST = 1'b1;
  localparam logic [0:0] WR_IDLE  = 1'b0;
  localparam logic [0:0] WR_DATA  = 1'b1;

  // ---------------------------------------------------------------- read path
  logic [0:0]    r_rd_state;
  logic [AW-1:0] r_rd_idx;
  logic [32:0]   r_rd_left;      // beats still to be fetched from memory
  logic [31:0]   r_rd_cmd_cnt;
  logic [1:0]    r_buf_last;
  logic          r_buf_wptr;
  logic          r_buf_rptr;
  logic [1:0]    r_buf_cnt;
  logic [32:0]   w_rd_beats;
  logic          w_rd_cmd_hs;
  logic          w_rd_pop;
  logic          w_rd_issue;
  logic [511:0]  w_rd_data;

  // ---------------------------------------------------------------- write path
  logic [0:0]    r_wr_state;
  logic [AW-1:0] r_wr_idx;
  logic [32:0]   r_wr_left;      // beats remaining before the length says stop
  logic [31:0]   r_wr_cmd_cnt;
  logic [31:0]   r_wr_err_cnt;
  logic [32:0]   w_wr_beats;
  logic          w_wr_cmd_hs;
  logic          w_wr_beat;
  logic          w_wr_end_cnt;
  logic          w_wr_end;

  // Only the word-index bits of the addresses are meaningful here.
  logic w_unused_addr;
  assign w_unused_addr = ^{s_axis_dma_read_cmd.address, s_axis_dma_write_cmd.address};

  // Beat count in 33 bits so a length near 4 GiB cannot overflow the round-up.
  assign w_rd_beats = ({1'b0, s_axis_dma_read_cmd.length} + 33'd63) >> 6;
  assign w_wr_beats = ({1'b0, s_axis_dma_write_cmd.length} + 33'd63) >> 6;

  assign s_axis_dma_read_cmd.ready = (r_rd_state == RD_IDLE);
  assign w_rd_cmd_hs = s_axis_dma_read_cmd.valid && (r_rd_state == RD_IDLE);
  assign w_rd_pop    = (r_buf_cnt != 2'd0) && m_axis_dma_read_data.ready;
  // The 2-entry buffer lets fetches run one cycle ahead of the consumer
  // without making the RAM enable depend combinationally on ready.
  assign w_rd_issue  = (r_rd_state == RD_BURST) && (r_rd_left != 33'd0) && (r_buf_cnt != 2'd2);

  assign m_axis_dma_read_data.valid = (r_buf_cnt != 2'd0);
  assign m_axis_dma_read_data.data  = w_rd_data;
  assign m_axis_dma_read_data.keep  = '1;
  assign m_axis_dma_read_data.last  = (r_buf_cnt != 2'd0) && r_buf_last[r_buf_rptr];

  assign s_axis_dma_write_cmd.ready  = (r_wr_state == WR_IDLE);
  assign s_axis_dma_write_data.ready = (r_wr_state == WR_DATA);
  assign w_wr_cmd_hs  = s_axis_dma_write_cmd.valid && (r_wr_state == WR_IDLE);
  assign w_wr_beat    = s_axis_dma_write_data.valid && (r_wr_state == WR_DATA);
  assign w_wr_end_cnt = (r_wr_left == 33'd1);
  assign w_wr_end     = w_wr_beat && (s_axis_dma_write_data.last || w_wr_end_cnt);

  assign o_rd_cmd_cnt = r_rd_cmd_cnt;
  assign o_wr_cmd_cnt = r_wr_cmd_cnt;
  assign o_wr_err_cnt = r_wr_err_cnt;

  // Memory split into byte lanes: each lane is a plain simple-dual-port array
  // with its own write enable, and its registered read lands directly in the
  // output buffer slot selected by the write pointer (read-first on collision).
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_lane
      logic [7:0] r_lane_mem [MEM_DEPTH];
      logic [7:0] r_lane_buf [2];

      always_ff @(posedge user_clk) begin
        if (w_wr_beat && s_axis_dma_write_data.keep[gi]) begin
          r_lane_mem[r_wr_idx] <= s_axis_dma_write_data.data[gi*8 +: 8];
        end
        if (w_rd_issue) begin
          r_lane_buf[r_buf_wptr] <= r_lane_mem[r_rd_idx];
        end
      end

      assign w_rd_data[gi*8 +: 8] = r_lane_buf[r_buf_rptr];
    end
  endgenerate

  always_ff @(posedge user_clk) begin
    if (w_rd_issue) begin
      r_buf_last[r_buf_wptr] <= (r_rd_left == 33'd1);
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_rd_state   <= RD_IDLE;
      r_rd_idx     <= '0;
      r_rd_left    <= '0;
      r_rd_cmd_cnt <= '0;
      r_buf_wptr   <= 1'b0;
      r_buf_rptr   <= 1'b0;
      r_buf_cnt    <= 2'd0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (w_rd_cmd_hs) begin
            r_rd_idx     <= s_axis_dma_read_cmd.address[AW+5:6];
            r_rd_left    <= w_rd_beats;
            r_rd_cmd_cnt <= r_rd_cmd_cnt + 32'd1;
            if (w_rd_beats != 33'd0) begin
              r_rd_state <= RD_BURST;
            end
          end
        end
        default: begin
          if (w_rd_pop && m_axis_dma_read_data.last) begin
            r_rd_state <= RD_IDLE;
          end
          if (w_rd_issue) begin
            r_rd_idx  <= r_rd_idx + AW'(1);
            r_rd_left <= r_rd_left - 33'd1;
          end
        end
      endcase
      if (w_rd_issue) begin
        r_buf_wptr <= ~r_buf_wptr;
      end
      if (w_rd_pop) begin
        r_buf_rptr <= ~r_buf_rptr;
      end
      r_buf_cnt <= r_buf_cnt + {1'b0, w_rd_issue} - {1'b0, w_rd_pop};
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_wr_state   <= WR_IDLE;
      r_wr_idx     <= '0;
      r_wr_left    <= '0;
      r_wr_cmd_cnt <= '0;
      r_wr_err_cnt <= '0;
    end else begin
      case (r_wr_state)
        WR_IDLE: begin
          if (w_wr_cmd_hs) begin
            r_wr_idx     <= s_axis_dma_write_cmd.address[AW+5:6];
            r_wr_left    <= w_wr_beats;
            r_wr_cmd_cnt <= r_wr_cmd_cnt + 32'd1;
            if (w_wr_beats != 33'd0) begin
              r_wr_state <= WR_DATA;
            end
          end
        end
        default: begin
          if (w_wr_beat) begin
            r_wr_idx  <= r_wr_idx + AW'(1);
            r_wr_left <= r_wr_left - 33'd1;
          end
          if (w_wr_end) begin
            r_wr_state <= WR_IDLE;
            // Exactly one of the two end conditions means sender and command disagree.
            if (s_axis_dma_write_data.last != w_wr_end_cnt) begin
              r_wr_err_cnt <= r_wr_err_cnt + 32'd1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dma_mem_responder.sv
module tb_dma_mem_responder;
  localparam int DEPTH = 16;

  logic user_clk = 1'b0;
  logic user_rst = 1'b1;
  always #5 user_clk = ~user_clk;

  int cyc = 0;
  always @(posedge user_clk) cyc <= cyc + 1;

  axis_mem_cmd_if rd_cmd();
  axis_mem_cmd_if wr_cmd();
  axi_stream_if   rd_data();
  axi_stream_if   wr_data();

  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic [31:0] err_cnt;

  dma_mem_responder #(.MEM_DEPTH(DEPTH)) dut (
    .user_clk              (user_clk),
    .user_rst              (user_rst),
    .s_axis_dma_read_cmd   (rd_cmd),
    .s_axis_dma_write_cmd  (wr_cmd),
    .m_axis_dma_read_data  (rd_data),
    .s_axis_dma_write_data (wr_data),
    .o_rd_cmd_cnt          (rd_cnt),
    .o_wr_cmd_cnt          (wr_cnt),
    .o_wr_err_cnt          (err_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: memory contents and expected counter values.
  logic [511:0] model_mem [DEPTH];
  logic [31:0]  m_rd  = 0;
  logic [31:0]  m_wr  = 0;
  logic [31:0]  m_err = 0;

  logic [511:0] tx_data [32];
  logic [63:0]  tx_keep [32];
  logic         tx_last [32];
  logic [511:0] rx_last_data;

  function automatic int beats_of(input logic [31:0] l);
    return int'((64'(l) + 64'd63) / 64'd64);
  endfunction

  task automatic fill_tx(input int lastpos, input bit full);
    for (int k = 0; k < 32; k++) begin
      for (int w = 0; w < 16; w++) tx_data[k][w*32 +: 32] = $urandom();
      tx_keep[k] = full ? '1 : {$urandom(), $urandom()};
      tx_last[k] = (k == lastpos);
    end
  endtask

  task automatic wr_txn(input logic [63:0] a, input logic [31:0] l, input int nsend);
    int nb, base, exp_acc, b, idx;
    bit exp_err, over;
    nb = beats_of(l);
    base = int'(a[9:6]);
    exp_acc = 0;
    exp_err = 0;
    if (nb > 0) begin
      for (int k = 0; k < nsend; k++) begin
        if (tx_last[k] || k == nb - 1) begin
          exp_acc = k + 1;
          exp_err = (tx_last[k] != (k == nb - 1));
          break;
        end
      end
    end
    wr_cmd.address = a;
    wr_cmd.length  = l;
    wr_cmd.valid   = 1'b1;
    b = 0;
    while (wr_cmd.ready !== 1'b1 && b < 20) begin @(negedge user_clk); b++; end
    if (b >= 20) begin n_checks++; $display("FAIL wr_cmd_timeout: ready=%b required 1", wr_cmd.ready); end
    @(negedge user_clk);
    wr_cmd.valid = 1'b0;
    m_wr = m_wr + 1;
    n_checks++;
    if (wr_data.ready !== 1'(nb != 0)) $display("FAIL wr_data_ready_T1: got %b required %b", wr_data.ready, nb != 0);
    else n_pass++;
    n_checks++;
    if (wr_cmd.ready !== 1'(nb == 0)) $display("FAIL wr_cmd_ready_busy: got %b required %b", wr_cmd.ready, nb == 0);
    else n_pass++;
    for (int k = 0; k < exp_acc; k++) begin
      wr_data.valid = 1'b1;
      wr_data.data  = tx_data[k];
      wr_data.keep  = tx_keep[k];
      wr_data.last  = tx_last[k];
      b = 0;
      while (wr_data.ready !== 1'b1 && b < 20) begin @(negedge user_clk); b++; end
      if (b >= 20) begin
        n_checks++;
        $display("FAIL wr_beat_timeout: beat %0d ready=%b required 1", k, wr_data.ready);
      end else begin
        idx = (base + k) % DEPTH;
        for (int by = 0; by < 64; by++)
          if (tx_keep[k][by]) model_mem[idx][by*8 +: 8] = tx_data[k][by*8 +: 8];
      end
      @(negedge user_clk);
    end
    n_checks++;
    if (wr_data.ready !== 1'b0 || wr_cmd.ready !== 1'b1)
      $display("FAIL wr_end: data.ready=%b cmd.ready=%b required 0/1", wr_data.ready, wr_cmd.ready);
    else n_pass++;
    if (nsend > exp_acc) begin
      wr_data.valid = 1'b1;
      wr_data.data  = tx_data[exp_acc];
      wr_data.keep  = tx_keep[exp_acc];
      wr_data.last  = tx_last[exp_acc];
      over = 0;
      repeat (3) begin
        if (wr_data.ready !== 1'b0) over = 1;
        @(negedge user_clk);
      end
      n_checks++;
      if (over) $display("FAIL wr_extra_beat: ready seen 1 required 0 after burst end");
      else n_pass++;
    end
    wr_data.valid = 1'b0;
    wr_data.last  = 1'b0;
    if (exp_err) m_err = m_err + 1;
    n_checks++;
    if (err_cnt !== m_err) $display("FAIL wr_err_cnt: got %0d required %0d", err_cnt, m_err);
    else n_pass++;
    n_checks++;
    if (wr_cnt !== m_wr) $display("FAIL wr_cmd_cnt: got %0d required %0d", wr_cnt, m_wr);
    else n_pass++;
    $display("WR addr=0x%0h len=%0d beats=%0d accepted=%0d err=%0d", a, l, nb, exp_acc, exp_err);
  endtask

  task automatic rd_txn(input logic [63:0] a, input logic [31:0] l, input int pct);
    int nb, base, k, b, t_hs, first;
    bit r, stall;
    logic [511:0] pd;
    logic pl;
    nb = beats_of(l);
    base = int'(a[9:6]);
    rd_cmd.address = a;
    rd_cmd.length  = l;
    rd_cmd.valid   = 1'b1;
    b = 0;
    while (rd_cmd.ready !== 1'b1 && b < 20) begin @(negedge user_clk); b++; end
    if (b >= 20) begin n_checks++; $display("FAIL rd_cmd_timeout: ready=%b required 1", rd_cmd.ready); end
    t_hs = cyc;
    @(negedge user_clk);
    rd_cmd.valid = 1'b0;
    m_rd = m_rd + 1;
    n_checks++;
    if (rd_cmd.ready !== 1'(nb == 0)) $display("FAIL rd_cmd_ready_busy: got %b required %b", rd_cmd.ready, nb == 0);
    else n_pass++;
    k = 0; b = 0; first = -1; stall = 0; pd = '0; pl = 1'b0;
    while (k < nb && b < 600) begin
      if (stall) begin
        n_checks++;
        if (rd_data.valid !== 1'b1 || rd_data.data !== pd || rd_data.last !== pl)
          $display("FAIL rd_hold: valid=%b last=%b data_same=%b required 1/%b/1", rd_data.valid, rd_data.last, rd_data.data === pd, pl);
        else n_pass++;
      end
      if (rd_data.valid === 1'b1 && first < 0) begin
        first = cyc;
        n_checks++;
        if (first != t_hs + 2) $display("FAIL rd_latency: first valid %0d cycles after cmd, required 2", first - t_hs);
        else n_pass++;
      end
      r = ($urandom_range(0, 99) < pct);
      rd_data.ready = r;
      if (rd_data.valid === 1'b1 && r) begin
        n_checks++;
        if (rd_data.data !== model_mem[(base + k) % DEPTH])
          $display("FAIL rd_data: beat %0d got 0x%0h required 0x%0h", k, rd_data.data[63:0], model_mem[(base + k) % DEPTH][63:0]);
        else n_pass++;
        n_checks++;
        if (rd_data.keep !== {64{1'b1}}) $display("FAIL rd_keep: beat %0d got 0x%0h required all ones", k, rd_data.keep);
        else n_pass++;
        n_checks++;
        if (rd_data.last !== 1'(k == nb - 1)) $display("FAIL rd_last: beat %0d got %b required %b", k, rd_data.last, k == nb - 1);
        else n_pass++;
        rx_last_data = rd_data.data;
        k++;
      end
      stall = (rd_data.valid === 1'b1) && !r;
      pd = rd_data.data;
      pl = rd_data.last;
      @(negedge user_clk);
      b++;
    end
    if (k < nb) begin n_checks++; $display("FAIL rd_timeout: got %0d beats required %0d", k, nb); end
    rd_data.ready = 1'b0;
    if (nb == 0) repeat (2) @(negedge user_clk);
    n_checks++;
    if (rd_cmd.ready !== 1'b1 || rd_data.valid !== 1'b0)
      $display("FAIL rd_done: cmd.ready=%b valid=%b required 1/0", rd_cmd.ready, rd_data.valid);
    else n_pass++;
    n_checks++;
    if (rd_cnt !== m_rd) $display("FAIL rd_cmd_cnt: got %0d required %0d", rd_cnt, m_rd);
    else n_pass++;
    $display("RD addr=0x%0h len=%0d beats=%0d received=%0d", a, l, nb, k);
  endtask

  task automatic test_reset();
    user_rst = 1'b1;
    repeat (3) @(negedge user_clk);
    user_rst = 1'b0;
    @(negedge user_clk);
    n_checks++;
    if (rd_cmd.ready !== 1'b1 || wr_cmd.ready !== 1'b1)
      $display("FAIL reset_cmd_ready: rd=%b wr=%b required 1/1", rd_cmd.ready, wr_cmd.ready);
    else n_pass++;
    n_checks++;
    if (rd_data.valid !== 1'b0 || rd_data.last !== 1'b0)
      $display("FAIL reset_rd_valid: valid=%b last=%b required 0/0", rd_data.valid, rd_data.last);
    else n_pass++;
    n_checks++;
    if (wr_data.ready !== 1'b0) $display("FAIL reset_wr_ready: got %b required 0", wr_data.ready);
    else n_pass++;
    n_checks++;
    if (rd_cnt !== 0 || wr_cnt !== 0 || err_cnt !== 0)
      $display("FAIL reset_counters: rd=%0d wr=%0d err=%0d required 0/0/0", rd_cnt, wr_cnt, err_cnt);
    else n_pass++;
    $display("RESET done");
  endtask

  task automatic test_write_readback();
    for (int k = 0; k < 32; k++) begin
      tx_data[k] = 512'(k);
      tx_keep[k] = '1;
      tx_last[k] = (k == 3);
    end
    wr_txn(64'h0, 32'd256, 4);
    rd_txn(64'h0, 32'd256, 100);
    n_checks++;
    if (rx_last_data !== 512'd3) $display("FAIL readback_beat3: got 0x%0h required 0x3", rx_last_data[63:0]);
    else n_pass++;
  endtask

  task automatic test_fill();
    fill_tx(15, 1'b1);
    wr_txn(64'h0, 32'd1024, 16);
    rd_txn(64'h0, 32'd1024, 100);
  endtask

  task automatic test_wrap();
    fill_tx(1, 1'b1);
    wr_txn(64'(15 * 64), 32'd100, 2);
    rd_txn(64'(15 * 64), 32'd100, 100);
  endtask

  task automatic test_mismatch();
    fill_tx(1, 1'b1);
    wr_txn(64'h0, 32'd256, 4);
    fill_tx(3, 1'b1);
    wr_txn(64'h0, 32'd128, 4);
    rd_txn(64'h0, 32'd256, 100);
  endtask

  task automatic test_zero_len();
    fill_tx(0, 1'b1);
    wr_txn(64'(3 * 64), 32'd0, 1);
    rd_txn(64'(3 * 64), 32'd0, 100);
  endtask

  task automatic test_byte_enable();
    fill_tx(0, 1'b1);
    tx_data[0] = '0;
    wr_txn(64'(5 * 64), 32'd64, 1);
    tx_data[0] = '1;
    tx_keep[0] = 64'h0F;
    wr_txn(64'(5 * 64), 32'd64, 1);
    rd_txn(64'(5 * 64), 32'd64, 100);
    n_checks++;
    if (rx_last_data !== {480'd0, 32'hFFFF_FFFF})
      $display("FAIL byte_enable: got 0x%0h required 0xffffffff in low bytes only", rx_last_data[127:0]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [63:0] a;
    rd_txn(64'h0, 32'd1024, 50);
    repeat (4) begin
      a = 64'($urandom_range(0, DEPTH - 1)) << 6;
      a[5:0] = 6'($urandom());
      a[63:32] = $urandom();
      rd_txn(a, 32'($urandom_range(1, 1024)), int'($urandom_range(50, 90)));
    end
  endtask

  task automatic test_random_writes();
    logic [63:0] a;
    logic [31:0] l;
    int nb;
    repeat (4) begin
      l = 32'($urandom_range(1, 1024));
      nb = beats_of(l);
      a = 64'($urandom_range(0, DEPTH - 1)) << 6;
      a[5:0] = 6'($urandom());
      a[63:32] = $urandom();
      fill_tx(int'($urandom_range(0, nb + 1)), 1'b0);
      wr_txn(a, l, nb + 2);
    end
    rd_txn(64'h0, 32'd1024, 50);
  endtask

  task automatic test_concurrent();
    user_rst = 1'b1;
    @(negedge user_clk);
    user_rst = 1'b0;
    m_rd = 0; m_wr = 0; m_err = 0;
    fill_tx(3, 1'b1);
    fork
      wr_txn(64'h0, 32'd256, 4);
      rd_txn(64'(8 * 64), 32'd256, 70);
    join
    n_checks++;
    if (rd_cnt !== 32'd1 || wr_cnt !== 32'd1)
      $display("FAIL concurrent_counts: rd=%0d wr=%0d required 1/1", rd_cnt, wr_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k, b;
    rd_cmd.address = 64'h0;
    rd_cmd.length  = 32'd512;
    rd_cmd.valid   = 1'b1;
    b = 0;
    while (rd_cmd.ready !== 1'b1 && b < 20) begin @(negedge user_clk); b++; end
    @(negedge user_clk);
    rd_cmd.valid = 1'b0;
    rd_data.ready = 1'b1;
    k = 0; b = 0;
    while (k < 2 && b < 50) begin
      if (rd_data.valid === 1'b1) k++;
      @(negedge user_clk);
      b++;
    end
    n_checks++;
    if (rd_data.valid !== 1'b1) $display("FAIL rst_mid_before: valid=%b required 1 at beat 2", rd_data.valid);
    else n_pass++;
    user_rst = 1'b1;
    @(negedge user_clk);
    n_checks++;
    if (rd_data.valid !== 1'b0 || rd_cmd.ready !== 1'b1 || wr_cmd.ready !== 1'b1 || wr_data.ready !== 1'b0)
      $display("FAIL rst_mid_state: valid=%b rd_cmd=%b wr_cmd=%b wr_data=%b required 0/1/1/0",
               rd_data.valid, rd_cmd.ready, wr_cmd.ready, wr_data.ready);
    else n_pass++;
    n_checks++;
    if (rd_cnt !== 0 || wr_cnt !== 0 || err_cnt !== 0)
      $display("FAIL rst_mid_counters: rd=%0d wr=%0d err=%0d required 0/0/0", rd_cnt, wr_cnt, err_cnt);
    else n_pass++;
    user_rst = 1'b0;
    rd_data.ready = 1'b0;
    m_rd = 0; m_wr = 0; m_err = 0;
    $display("RESET mid-burst at beat %0d", k);
    rd_txn(64'h0, 32'd512, 100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_cmd.valid = 1'b0; rd_cmd.address = '0; rd_cmd.length = '0;
    wr_cmd.valid = 1'b0; wr_cmd.address = '0; wr_cmd.length = '0;
    rd_data.ready = 1'b0;
    wr_data.valid = 1'b0; wr_data.data = '0; wr_data.keep = '0; wr_data.last = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    @(negedge user_clk);
    test_reset();
    test_write_readback();
    test_fill();
    test_wrap();
    test_mismatch();
    test_zero_len();
    test_byte_enable();
    test_backpressure();
    test_random_writes();
    test_concurrent();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
